// File: rtl/ula_pkg.sv
// Shared types and constants for the ULA datapath and its writeback stage.
package ula_pkg;

  localparam int unsigned ULA_WIDTH = 32;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } ula_flags_t;

  typedef enum logic [1:0] {ULA_ADD, ULA_SUB, ULA_AND, ULA_OR} ula_op_t;

  // Occupancy states of the writeback FIFO
  localparam logic [1:0] OCC_VAZIO   = 2'd0;
  localparam logic [1:0] OCC_PARCIAL = 2'd1;
  localparam logic [1:0] OCC_CHEIO   = 2'd2;

endpackage

// File: rtl/ula_fifo.sv
// DEPTH-entry synchronous FIFO with flush; full/empty decoded from a registered occupancy state.
module ula_fifo
  import ula_pkg::*;
#(
  parameter int unsigned W     = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       occ_q, occ_d;

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(1));
      if (pop)  rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
      if (push && !pop)      count_d = CNT_W'(count_q + CNT_W'(1));
      else if (pop && !push) count_d = CNT_W'(count_q - CNT_W'(1));
    end
    if (count_d == '0)                 occ_d = OCC_VAZIO;
    else if (count_d == CNT_W'(DEPTH)) occ_d = OCC_CHEIO;
    else                               occ_d = OCC_PARCIAL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      occ_q    <= OCC_VAZIO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (occ_q == OCC_CHEIO);
  assign empty = (occ_q == OCC_VAZIO);

endmodule

// File: rtl/ula_estagio_wb.sv
// ULA writeback stage: result FIFO toward the register file, NZCV register and overflow monitor.
module ula_estagio_wb
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH  = ULA_WIDTH,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_resultado,
  input  logic              in_zero,
  input  logic              in_negativo,
  input  logic              in_carry,
  input  logic              in_overflow,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_set_flags,
  input  logic              flush,
  input  logic              clr_sticky,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [WIDTH-1:0]  wb_dado,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [3:0]        flags_nzcv,
  output logic              ovf_sticky,
  output logic [CNT_W-1:0]  ovf_count
);

  localparam int unsigned ENT_W = WIDTH + ADDR_W;

  logic             accept_c, push_c, pop_c;
  logic             fifo_full, fifo_empty;
  logic [ENT_W-1:0] head;

  ula_flags_t       flags_q, flags_d;
  logic             ovf_sticky_q, ovf_sticky_d;
  logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

  // in_ready depends only on registered occupancy and flush, never on wb_ready
  assign in_ready = !fifo_full && !flush;
  assign accept_c = in_valid && in_ready;
  assign push_c   = accept_c && (in_rd != '0);
  assign wb_valid = !fifo_empty;
  assign pop_c    = wb_valid && wb_ready;

  ula_fifo #(.W(ENT_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .pop   (pop_c),
    .flush (flush),
    .din   ({in_rd, in_resultado}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign wb_dado = wb_valid ? head[WIDTH-1:0]     : '0;
  assign wb_rd   = wb_valid ? head[ENT_W-1:WIDTH] : '0;

  // Overflow set has priority over clear in the same cycle
  always_comb begin
    flags_d      = flags_q;
    ovf_sticky_d = ovf_sticky_q;
    ovf_count_d  = ovf_count_q;
    if (accept_c && in_set_flags) begin
      flags_d = '{n: in_negativo, z: in_zero, c: in_carry, v: in_overflow};
    end
    if (clr_sticky) begin
      ovf_sticky_d = 1'b0;
      ovf_count_d  = '0;
    end
    if (accept_c && in_overflow) begin
      ovf_sticky_d = 1'b1;
      if (clr_sticky)                         ovf_count_d = CNT_W'(1);
      else if (ovf_count_q != {CNT_W{1'b1}})  ovf_count_d = CNT_W'(ovf_count_q + CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q      <= '0;
      ovf_sticky_q <= 1'b0;
      ovf_count_q  <= '0;
    end else begin
      flags_q      <= flags_d;
      ovf_sticky_q <= ovf_sticky_d;
      ovf_count_q  <= ovf_count_d;
    end
  end

  assign flags_nzcv = flags_q;
  assign ovf_sticky = ovf_sticky_q;
  assign ovf_count  = ovf_count_q;

endmodule

// File: tb/tb_ula_estagio_wb.sv
// Directed bench for ula_estagio_wb: vector table plus hand-written multi-cycle sequences.
module tb_ula_estagio_wb;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready;
  logic [WIDTH-1:0]  in_resultado;
  logic              in_zero, in_negativo, in_carry, in_overflow;
  logic [ADDR_W-1:0] in_rd;
  logic              in_set_flags, flush, clr_sticky;
  logic              wb_valid, wb_ready;
  logic [WIDTH-1:0]  wb_dado;
  logic [ADDR_W-1:0] wb_rd;
  logic [3:0]        flags_nzcv;
  logic              ovf_sticky;
  logic [CNT_W-1:0]  ovf_count;

  int checks = 0;
  int errors = 0;

  ula_estagio_wb #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_resultado (in_resultado),
    .in_zero      (in_zero),
    .in_negativo  (in_negativo),
    .in_carry     (in_carry),
    .in_overflow  (in_overflow),
    .in_rd        (in_rd),
    .in_set_flags (in_set_flags),
    .flush        (flush),
    .clr_sticky   (clr_sticky),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_dado      (wb_dado),
    .wb_rd        (wb_rd),
    .flags_nzcv   (flags_nzcv),
    .ovf_sticky   (ovf_sticky),
    .ovf_count    (ovf_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] res;
    logic        n, z, c, v;
    logic [4:0]  rd;
    logic        set;
    logic        wbr;
    logic        e_ir;
    logic        e_wv;
    logic [31:0] e_dado;
    logic [4:0]  e_rd;
    logic [3:0]  e_flags;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd,
                       input logic set, input logic n, input logic z, input logic c,
                       input logic o);
    in_valid = v; in_resultado = res; in_rd = rd; in_set_flags = set;
    in_negativo = n; in_zero = z; in_carry = c; in_overflow = o;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; clr_sticky = 1'b0; wb_ready = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    //        valid res            n  z  c  v  rd     set wbr ir wv dado           rd     flags
    vecs[0] = '{1'b1, 32'h0000_0005, 0, 0, 0, 0, 5'd3,  1, 0, 1, 1, 32'h0000_0005, 5'd3,  4'b0000};
    vecs[1] = '{1'b1, 32'h0000_0000, 0, 1, 1, 0, 5'd0,  1, 1, 1, 0, 32'h0000_0000, 5'd0,  4'b0110};
    vecs[2] = '{1'b1, 32'h0000_0000, 0, 1, 1, 0, 5'd0,  1, 0, 1, 0, 32'h0000_0000, 5'd0,  4'b0110};
    vecs[3] = '{1'b1, 32'h8000_0000, 1, 0, 0, 0, 5'd7,  0, 0, 1, 1, 32'h8000_0000, 5'd7,  4'b0110};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF, 1, 0, 1, 0, 5'd31, 1, 0, 1, 1, 32'h8000_0000, 5'd7,  4'b1010};
    vecs[5] = '{1'b1, 32'h0000_0009, 0, 0, 0, 0, 5'd2,  1, 1, 0, 1, 32'hFFFF_FFFF, 5'd31, 4'b1010};
    vecs[6] = '{1'b0, 32'h0000_0000, 0, 0, 0, 0, 5'd0,  0, 1, 1, 0, 32'h0000_0000, 5'd0,  4'b1010};
    vecs[7] = '{1'b1, 32'h0000_002A, 0, 0, 0, 0, 5'd1,  1, 0, 1, 1, 32'h0000_002A, 5'd1,  4'b0000};
    vecs[8] = '{1'b0, 32'h0000_0000, 0, 0, 0, 0, 5'd0,  0, 1, 1, 0, 32'h0000_0000, 5'd0,  4'b0000};

    #12 rst_n = 1'b1;
    #1;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_flags", 32'(flags_nzcv), 32'd0);
    chk("rst_sticky", 32'(ovf_sticky), 32'd0);
    chk("rst_count", 32'(ovf_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    cyc();

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].valid, vecs[i].res, vecs[i].rd, vecs[i].set,
            vecs[i].n, vecs[i].z, vecs[i].c, vecs[i].v);
      wb_ready = vecs[i].wbr;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      cyc();
      chk($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'(vecs[i].e_wv));
      chk($sformatf("v%0d_wb_dado", i), wb_dado, vecs[i].e_dado);
      chk($sformatf("v%0d_wb_rd", i), 32'(wb_rd), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d_flags", i), 32'(flags_nzcv), 32'(vecs[i].e_flags));
    end

    // Backpressure: fill, refuse a third entry, then drain in order
    wb_ready = 1'b0;
    drive(1'b1, 32'h11, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'h22, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'h33, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    cyc();
    chk("bp_head_dado", wb_dado, 32'h11);
    chk("bp_head_rd", 32'(wb_rd), 32'd4);
    in_valid = 1'b0;
    wb_ready = 1'b1;
    #1;
    chk("bp_full_pop_in_ready", 32'(in_ready), 32'd0);
    cyc();
    chk("bp_pop1_dado", wb_dado, 32'h22);
    chk("bp_pop1_rd", 32'(wb_rd), 32'd5);
    chk("bp_pop1_in_ready", 32'(in_ready), 32'd1);
    cyc();
    chk("bp_drained", 32'(wb_valid), 32'd0);
    wb_ready = 1'b0;

    // Overflow monitor saturation and clear/set priority
    clr_sticky = 1'b1;
    cyc();
    clr_sticky = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 32'h8000_0000, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      cyc();
      chk($sformatf("ovf_count_%0d", i), 32'(ovf_count), (i > 3) ? 32'd3 : 32'(i));
      chk($sformatf("ovf_sticky_%0d", i), 32'(ovf_sticky), 32'd1);
    end
    chk("ovf_no_push", 32'(wb_valid), 32'd0);
    chk("ovf_flags_hold", 32'(flags_nzcv), 32'd0);
    in_valid = 1'b0;
    clr_sticky = 1'b1;
    cyc();
    chk("clr_sticky", 32'(ovf_sticky), 32'd0);
    chk("clr_count", 32'(ovf_count), 32'd0);
    in_valid = 1'b1;
    cyc();
    chk("clr_set_sticky", 32'(ovf_sticky), 32'd1);
    chk("clr_set_count", 32'(ovf_count), 32'd1);
    clr_sticky = 1'b0;

    // Flush with two entries buffered and a competing accept attempt
    drive(1'b1, 32'h100, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'h200, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("fl_pre_dado", wb_dado, 32'h100);
    drive(1'b1, 32'h300, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    flush = 1'b1;
    #1;
    chk("fl_in_ready", 32'(in_ready), 32'd0);
    cyc();
    flush = 1'b0;
    chk("fl_wb_valid", 32'(wb_valid), 32'd0);
    chk("fl_flags", 32'(flags_nzcv), 32'd0);
    chk("fl_ovf_count", 32'(ovf_count), 32'd1);
    drive(1'b1, 32'h77, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("fl_after_in_ready", 32'(in_ready), 32'd1);
    cyc();
    chk("fl_after_dado", wb_dado, 32'h77);
    chk("fl_after_rd", 32'(wb_rd), 32'd2);
    in_valid = 1'b0;
    wb_ready = 1'b1;
    cyc();
    chk("fl_after_empty", 32'(wb_valid), 32'd0);

    // Streaming push+pop with pointer wrap, then reset mid-stream
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 32'(i), 5'((i % 8) + 1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
      chk($sformatf("st_valid_%0d", i), 32'(wb_valid), 32'd1);
      chk($sformatf("st_dado_%0d", i), wb_dado, 32'(i));
      chk($sformatf("st_rd_%0d", i), 32'(wb_rd), 32'((i % 8) + 1));
    end
    drive(1'b1, 32'd11, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wb_valid", 32'(wb_valid), 32'd0);
    chk("arst_wb_dado", wb_dado, 32'd0);
    chk("arst_sticky", 32'(ovf_sticky), 32'd0);
    in_valid = 1'b0;
    #3 rst_n = 1'b1;
    cyc();
    chk("arst_after_valid", 32'(wb_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
